// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch stage: one outstanding word fetch, DEPTH-entry {instr, npc} queue to decode.
// Optional feature macro: PREFETCH_BYPASS_EN (forward a response to decode when the queue is empty).
module fetch_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_update,
  input  logic [31:0] pc_new,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] ir_o,
  output logic [31:0] npc
);
  localparam int unsigned   PW       = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_ZERO = (PW+1)'(0);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ZERO = PW'(0);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_RSP  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          drop_q, drop_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [31:0]   ir_mem_q  [DEPTH];
  logic [31:0]   npc_mem_q [DEPTH];
  logic          rsp_ok_s, push_s, pop_s, bypass_s, room_s;

  // A usable response; in RSP fetch_pc_q already holds the fetched address + 4
  always_comb begin
    rsp_ok_s = (state_q == S_RSP) && imem_rvalid && !drop_q && !pc_update;
`ifdef PREFETCH_BYPASS_EN
    bypass_s = rsp_ok_s && (count_q == CNT_ZERO);
    push_s   = rsp_ok_s && !(bypass_s && ir_ready);
`else
    bypass_s = 1'b0;
    push_s   = rsp_ok_s;
`endif
    pop_s    = (count_q != CNT_ZERO) && ir_ready && !pc_update;
  end

  // Queue pointers and occupancy; a redirect empties the queue
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pc_update) begin
      count_d  = CNT_ZERO;
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
    end else begin
      if (push_s) wr_ptr_d = wr_ptr_q + PTR_ONE;
      else        wr_ptr_d = wr_ptr_q;
      if (pop_s)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      else        rd_ptr_d = rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
    room_s = (count_d < CNT_FULL);
  end

  // Fetch FSM; REQ is only entered with a free slot so a response always fits
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    case (state_q)
      S_REQ: begin
        if (imem_gnt) begin
          state_d    = S_RSP;
          fetch_pc_d = fetch_pc_q + 32'd4;
          drop_d     = pc_update;
        end else begin
          state_d = S_REQ;
        end
      end
      S_RSP: begin
        if (imem_rvalid) begin
          drop_d  = 1'b0;
          state_d = room_s ? S_REQ : S_HOLD;
        end else if (pc_update) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
      end
      S_HOLD: begin
        if (room_s) state_d = S_REQ;
        else        state_d = S_HOLD;
      end
      default: begin
        state_d = S_REQ;
        drop_d  = 1'b0;
      end
    endcase
    if (pc_update) fetch_pc_d = pc_new & 32'hFFFF_FFFC;
    else           fetch_pc_d = fetch_pc_d;
  end

  // Memory-side and decode-side outputs
  always_comb begin
    imem_req  = rst && (state_q == S_REQ);
    imem_addr = fetch_pc_q;
    ir_valid  = (count_q != CNT_ZERO) || bypass_s;
    if (bypass_s) begin
      ir_o = imem_rdata;
      npc  = fetch_pc_q;
    end else begin
      ir_o = ir_mem_q[rd_ptr_q];
      npc  = npc_mem_q[rd_ptr_q];
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      drop_q     <= 1'b0;
      wr_ptr_q   <= PTR_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      count_q    <= CNT_ZERO;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage, cleared so decode outputs read zero in reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ir_mem_q[i]  <= 32'h0;
        npc_mem_q[i] <= 32'h0;
      end
    end else if (push_s) begin
      ir_mem_q[wr_ptr_q]  <= imem_rdata;
      npc_mem_q[wr_ptr_q] <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Randomized self-checking bench for fetch_prefetch_buffer against a sequential-PC reference model.
module tb_fetch_prefetch_buffer;
  logic        clk = 1'b0;
  logic        rst, pc_update, imem_gnt, imem_rvalid, ir_ready;
  logic [31:0] pc_new, imem_rdata;
  logic        imem_req, ir_valid, w_req, w_valid;
  logic [31:0] imem_addr, ir_o, npc, w_addr, w_ir, w_npc;

  int total = 0;
  int bad   = 0;
  int gnt_pct, rv_pct, rv_maxw;
  bit force_rv;
  bit pending;
  logic [31:0] pend_addr;
  int pend_wait;

  bit          s_rst, s_req, s_gnt, s_rvalid, s_valid, s_ready, s_upd, s_pend, s_wreq, s_wvalid;
  logic [31:0] s_addr, s_ir, s_npc, s_pcnew, s_waddr, s_wnpc;

  fetch_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .pc_update(pc_update), .pc_new(pc_new),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_o(ir_o), .npc(npc)
  );

  // Same stimulus, reset PC at the top of the address space
  fetch_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .pc_update(pc_update), .pc_new(pc_new),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ir_valid(w_valid), .ir_ready(ir_ready), .ir_o(w_ir), .npc(w_npc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h2001_0005;
  endfunction

  // One clock: memory model drives at negedge, outputs sampled 2ns later, state updated at posedge
  task automatic tick();
    @(negedge clk);
    imem_gnt    = (rst && imem_req && !pending) ? ($urandom_range(99) < gnt_pct) : 1'b0;
    imem_rvalid = force_rv || (pending && pend_wait == 0 && ($urandom_range(99) < rv_pct));
    imem_rdata  = (pending && !force_rv) ? memf(pend_addr) : $urandom;
    #2;
    s_rst = rst; s_req = imem_req; s_addr = imem_addr; s_gnt = imem_gnt;
    s_rvalid = imem_rvalid; s_valid = ir_valid; s_ir = ir_o; s_npc = npc;
    s_ready = ir_ready; s_upd = pc_update; s_pcnew = pc_new; s_pend = pending;
    s_wreq = w_req; s_waddr = w_addr; s_wvalid = w_valid; s_wnpc = w_npc;
    @(posedge clk);
    if (!rst) begin
      pending = 1'b0;
    end else begin
      if (s_rvalid) pending = 1'b0;
      else if (pending && pend_wait > 0) pend_wait--;
      if (s_req && s_gnt) begin
        pending   = 1'b1;
        pend_addr = s_addr;
        pend_wait = $urandom_range(rv_maxw);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; pc_update = 1'b0; ir_ready = 1'b0; force_rv = 1'b0;
    gnt_pct = 100; rv_pct = 100; rv_maxw = 0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; pc_update = 1'b0; ir_ready = 1'b0; gnt_pct = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if ({s_req, s_valid, s_ir, s_npc} !== 66'h0) begin
        bad++;
        $display("FAIL reset_outputs: req=%b valid=%b ir=%h npc=%h want all zero", s_req, s_valid, s_ir, s_npc);
      end
    end
    rst = 1'b1;
    tick();
    total++;
    if (s_req !== 1'b1 || s_addr !== 32'h0 || s_valid !== 1'b0) begin
      bad++;
      $display("FAIL release: req=%b addr=%h valid=%b want 1/00000000/0", s_req, s_addr, s_valid);
    end
    total++;
    if (s_waddr !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL release_wrap_addr: got %h want fffffffc", s_waddr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] ga[$], wga[$], pir[$], pnpc[$], wnpc[$];
    do_reset();
    ir_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (s_req && s_gnt) ga.push_back(s_addr);
      if (s_wreq && s_gnt) wga.push_back(s_waddr);
      if (s_valid && s_ready) begin pir.push_back(s_ir); pnpc.push_back(s_npc); end
      if (s_wvalid && s_ready) wnpc.push_back(s_wnpc);
    end
    total++;
    if (ga.size() < 4 || pir.size() < 1 || wga.size() < 2 || wnpc.size() < 1) begin
      bad++;
      $display("FAIL stream_progress: grants=%0d pops=%0d wgrants=%0d wpops=%0d", ga.size(), pir.size(), wga.size(), wnpc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (ga[i] !== 32'(i * 4)) begin
          bad++;
          $display("FAIL stream_addr%0d: got %h want %h", i, ga[i], 32'(i * 4));
        end
      end
      total++;
      if (pir[0] !== 32'h2001_0005 || pnpc[0] !== 32'h4) begin
        bad++;
        $display("FAIL stream_first: ir=%h npc=%h want 20010005/00000004", pir[0], pnpc[0]);
      end
      total++;
      if (wnpc[0] !== 32'h0 || wga[1] !== 32'h0) begin
        bad++;
        $display("FAIL pc_wrap: npc=%h second_addr=%h want 0/0", wnpc[0], wga[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    int ngr;
    int npop;
    ngr = 0; npop = 0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      tick();
      if (s_req && s_gnt) ngr++;
      if (s_valid) begin
        total++;
        if (s_ir !== memf(32'h0) || s_npc !== 32'h4) begin
          bad++;
          $display("FAIL bp_hold: ir=%h npc=%h want %h/00000004", s_ir, s_npc, memf(32'h0));
        end
      end
    end
    total++;
    if (ngr != 4 || s_req !== 1'b0 || s_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_full: grants=%0d req=%b valid=%b want 4/0/1", ngr, s_req, s_valid);
    end
    ir_ready = 1'b1;
    for (int c = 0; c < 20 && npop < 4; c++) begin
      tick();
      if (s_valid && s_ready) begin
        total++;
        if (s_npc !== 32'(npop * 4 + 4) || s_ir !== memf(32'(npop * 4))) begin
          bad++;
          $display("FAIL bp_drain%0d: ir=%h npc=%h want %h/%h", npop, s_ir, s_npc, memf(32'(npop * 4)), 32'(npop * 4 + 4));
        end
        npop++;
      end
    end
    total++;
    if (npop != 4) begin
      bad++;
      $display("FAIL bp_drain_timeout: pops=%0d want 4", npop);
    end
  endtask

  task automatic test_redirect();
    bit got;
    bit gdone;
    bit pdone;
    got = 1'b0; gdone = 1'b0; pdone = 1'b0;
    do_reset();
    ir_ready = 1'b1;
    for (int c = 0; c < 60 && !got; c++) begin
      tick();
      if (s_req && s_gnt && s_addr == 32'h10) got = 1'b1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL redir_setup: got no grant at 00000010 want one");
    end
    rv_pct = 0; pc_update = 1'b1; pc_new = 32'h0000_0103;
    tick();
    pc_update = 1'b0; rv_pct = 100;
    for (int c = 0; c < 30 && !(gdone && pdone); c++) begin
      tick();
      if (s_req && s_gnt && !gdone) begin
        gdone = 1'b1;
        total++;
        if (s_addr !== 32'h100) begin
          bad++;
          $display("FAIL redir_addr: got %h want 00000100", s_addr);
        end
      end
      if (s_valid && s_ready && !pdone) begin
        pdone = 1'b1;
        total++;
        if (s_ir !== memf(32'h100) || s_npc !== 32'h104) begin
          bad++;
          $display("FAIL redir_first: ir=%h npc=%h want %h/00000104", s_ir, s_npc, memf(32'h100));
        end
      end
    end
    total++;
    if (!(gdone && pdone)) begin
      bad++;
      $display("FAIL redir_timeout: grant=%b pop=%b want 1/1", gdone, pdone);
    end
  endtask

  task automatic test_reset_mid();
    bit pdone;
    pdone = 1'b0;
    do_reset();
    ir_ready = 1'b1; rv_pct = 0;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1; gnt_pct = 0; force_rv = 1'b1;
    tick();
    force_rv = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h0) begin
        bad++;
        $display("FAIL stale_rvalid: valid=%b req=%b addr=%h want 0/1/00000000", s_valid, s_req, s_addr);
      end
    end
    gnt_pct = 100; rv_pct = 100;
    for (int c = 0; c < 10 && !pdone; c++) begin
      tick();
      if (s_valid && s_ready) begin
        pdone = 1'b1;
        total++;
        if (s_ir !== memf(32'h0) || s_npc !== 32'h4) begin
          bad++;
          $display("FAIL after_reset_pop: ir=%h npc=%h want %h/00000004", s_ir, s_npc, memf(32'h0));
        end
      end
    end
    total++;
    if (!pdone) begin
      bad++;
      $display("FAIL after_reset_timeout: no pop want one");
    end
  endtask

  task automatic test_latency();
    bit exp_same;
`ifdef PREFETCH_BYPASS_EN
    exp_same = 1'b1;
`else
    exp_same = 1'b0;
`endif
    do_reset();
    ir_ready = 1'b1;
    tick();
    tick();
    total++;
    if (s_rvalid !== 1'b1 || s_valid !== exp_same) begin
      bad++;
      $display("FAIL latency_same: rvalid=%b valid=%b want 1/%b", s_rvalid, s_valid, exp_same);
    end
    if (exp_same) begin
      total++;
      if (s_ir !== memf(32'h0) || s_npc !== 32'h4) begin
        bad++;
        $display("FAIL bypass_data: ir=%h npc=%h want %h/00000004", s_ir, s_npc, memf(32'h0));
      end
    end
    tick();
    total++;
    if (s_valid !== !exp_same) begin
      bad++;
      $display("FAIL latency_next: valid=%b want %b", s_valid, !exp_same);
    end
    if (!exp_same) begin
      total++;
      if (s_ir !== memf(32'h0) || s_npc !== 32'h4) begin
        bad++;
        $display("FAIL latency_data: ir=%h npc=%h want %h/00000004", s_ir, s_npc, memf(32'h0));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_fetch, exp_pop, prev_ir, prev_npc;
    bit prev_hold;
    exp_fetch = 32'h0; exp_pop = 32'h0; prev_hold = 1'b0;
    do_reset();
    gnt_pct = 70; rv_pct = 60; rv_maxw = 2;
    for (int c = 0; c < 4000; c++) begin
      ir_ready  = ($urandom_range(99) < 60);
      pc_update = ($urandom_range(99) < 3);
      pc_new    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      rst       = ($urandom_range(999) < 4) ? 1'b0 : 1'b1;
      tick();
      if (!s_rst) begin
        exp_fetch = 32'h0; exp_pop = 32'h0; prev_hold = 1'b0;
        total++;
        if (s_req !== 1'b0 || s_valid !== 1'b0) begin
          bad++;
          $display("FAIL rnd_reset: req=%b valid=%b want 0/0", s_req, s_valid);
        end
      end else begin
        if (prev_hold) begin
          total++;
          if (s_valid !== 1'b1 || s_ir !== prev_ir || s_npc !== prev_npc) begin
            bad++;
            $display("FAIL rnd_stable: valid=%b ir=%h npc=%h want 1/%h/%h", s_valid, s_ir, s_npc, prev_ir, prev_npc);
          end
        end
        if (s_req) begin
          total++;
          if (s_pend) begin
            bad++;
            $display("FAIL rnd_outstanding: req=1 with response pending want req=0");
          end
        end
        if (s_req && s_gnt) begin
          total++;
          if (s_addr !== exp_fetch) begin
            bad++;
            $display("FAIL rnd_addr: got %h want %h", s_addr, exp_fetch);
          end
          exp_fetch = exp_fetch + 32'd4;
        end
        if (s_valid && s_ready && !s_upd) begin
          total++;
          if (s_ir !== memf(exp_pop) || s_npc !== exp_pop + 32'd4) begin
            bad++;
            $display("FAIL rnd_pop: ir=%h npc=%h want %h/%h", s_ir, s_npc, memf(exp_pop), exp_pop + 32'd4);
          end
          exp_pop = exp_pop + 32'd4;
        end
        prev_hold = s_valid && !s_ready && !s_upd;
        prev_ir   = s_ir;
        prev_npc  = s_npc;
        if (s_upd) begin
          exp_fetch = s_pcnew & 32'hFFFF_FFFC;
          exp_pop   = s_pcnew & 32'hFFFF_FFFC;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; pc_update = 1'b0; pc_new = 32'h0; ir_ready = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    force_rv = 1'b0; pending = 1'b0; pend_addr = 32'h0; pend_wait = 0;
    gnt_pct = 100; rv_pct = 100; rv_maxw = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_reset_mid();
    test_latency();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
